element_stack: RTL and testbench
================================

// Module: element_stack
// PURPOSE
//   Downstream of element_parser: consumes completed start/end tags and tracks document nesting.
//   Each start tag becomes a node record {id, tag, parent id, depth}; each end tag closes the node on top of the stack.
//   Feeds the layout/render stage and flags malformed markup (mismatch, underflow, overflow, trailing tags).
// PARAMETERS
//   STACK_DEPTH  16  max simultaneously open elements
//   SP_BITS      5   stack pointer width; must hold 0..STACK_DEPTH
//   NODE_BITS    8   node id width; all-ones value = ROOT (no parent)
// PORTS
//   clock          in   1               single clock, all state updates on posedge
//   reset          in   1               synchronous, active-high
//   elem_done      in   1               element_parser has_finished (level; held high until parser disabled)
//   element_tag    in   `ELE_TAG_BITES  tag code (0 div, 1 p, 2 body, 3 a, 4 i)
//   element_type   in   1               0 start tag, 1 end tag
//   node_valid     out  1               1-cycle pulse: node record valid
//   node_id        out  NODE_BITS       id of new node, sequential from 0
//   node_tag       out  `ELE_TAG_BITES  tag of new node
//   node_parent    out  NODE_BITS       id of enclosing node; all-ones if top level
//   node_depth     out  SP_BITS         nesting depth of new node (top level = 0)
//   close_valid    out  1               1-cycle pulse: node closed
//   close_id       out  NODE_BITS       id of closed node
//   doc_done       out  1               sticky: stack returned to empty after >=1 node
//   err_flags      out  4               sticky {trailing, overflow, underflow, mismatch}
//   max_depth      out  SP_BITS         stats (see CONFIGURATION)
//   node_count     out  NODE_BITS       stats (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all outputs 0, sp=0, next_id=0, elem_done_q=0, FSM=S_EMPTY. Reset overrides any event in progress.
//   - Event = elem_done & ~elem_done_q (registered rising edge). Exactly one action per parser tag.
//   - Latency 1: outputs for an event register on the same posedge that samples it. valid pulses last one cycle.
//   - FSM: S_EMPTY -(start)-> S_OPEN; S_OPEN -(end, sp becomes 0)-> S_DONE. S_DONE is terminal until reset.
//   - Start tag, tag != 4, sp < STACK_DEPTH:
//     push {tag, next_id}; emit node (parent = top id, or all-ones if sp==0; depth = old sp); sp++, next_id++.
//   - Start tag, tag == 4 (void image): emit node as above. No push, no close_valid, sp unchanged.
//   - Start tag, sp == STACK_DEPTH: set overflow; no emit, no push, no id consumed.
//   - Start tag in S_DONE: set trailing; no emit; nothing else changes.
//   - End tag, sp == 0: set underflow; nothing else changes.
//   - End tag, top tag != element_tag: set mismatch; still pop and emit close_valid (recovery).
//   - End tag, matching: pop, emit close_valid/close_id; if new sp == 0 go to S_DONE and set doc_done.
//   - next_id saturates at all-ones minus 1. A start tag at saturation emits no node and sets overflow.
//   - Record outputs (node_*, close_id) hold their last values between pulses.
// CONFIGURATION
//   ELEMENT_STACK_STATS_EN defined:
//     max_depth = peak sp since reset.
//     node_count = nodes emitted since reset (void nodes included).
//   ELEMENT_STACK_STATS_EN undefined: max_depth and node_count tied to 0, no stats registers.
// TESTING
//   - body>div>p, then /p /div /body:
//     nodes (0,2,ROOT,0), (1,0,0,1), (2,1,1,2); closes 2,1,0; doc_done=1; err_flags=0.
//   - body, i, /body:
//     image node id1 parent0 depth1; single close_valid (id0); doc_done=1.
//   - body, div, /p:
//     mismatch=1, close_id=1, sp=1. Then /body: close_id=0, doc_done=1.
//   - /div with stack empty: underflow=1; no pulses. Then body: node id0 still emitted.
//   - STACK_DEPTH+1 nested div: overflow=1 on the last one; STACK_DEPTH nodes emitted.
//     With STATS_EN: max_depth=16.
//   - elem_done held high 5 cycles: exactly one node_valid. Reset mid-document: all outputs 0, next node id0.

Source files
------------

// File: rtl/element_stack.sv
// element_stack: tracks tag nesting into node/close records with sticky error flags; ELEMENT_STACK_STATS_EN adds max_depth/node_count stats
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 3
`endif
module element_stack #(
  parameter int STACK_DEPTH = 16,
  parameter int SP_BITS = 5,
  parameter int NODE_BITS = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      elem_done,
  input  logic [`ELE_TAG_BITES-1:0] element_tag,
  input  logic                      element_type,
  output logic                      node_valid,
  output logic [NODE_BITS-1:0]      node_id,
  output logic [`ELE_TAG_BITES-1:0] node_tag,
  output logic [NODE_BITS-1:0]      node_parent,
  output logic [SP_BITS-1:0]        node_depth,
  output logic                      close_valid,
  output logic [NODE_BITS-1:0]      close_id,
  output logic                      doc_done,
  output logic [3:0]                err_flags,
  output logic [SP_BITS-1:0]        max_depth,
  output logic [NODE_BITS-1:0]      node_count
);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam logic [NODE_BITS-1:0] ROOT = '1;
  localparam logic [NODE_BITS-1:0] SAT = ROOT - 1'b1;
  localparam logic [SP_BITS-1:0] FULL = SP_BITS'(STACK_DEPTH);
  typedef enum logic [1:0] {S_EMPTY, S_OPEN, S_DONE} state_t;
  state_t state, state_n;
  logic [SP_BITS-1:0] sp;
  logic [NODE_BITS-1:0] next_id;
  logic elem_done_q;
  logic [`ELE_TAG_BITES-1:0] stk_tag [STACK_DEPTH];
  logic [NODE_BITS-1:0] stk_id [STACK_DEPTH];
  logic ev, start, stop, trailing, ovf, emit, push, pop, underflow, mismatch;
  logic [IW-1:0] top_i;
  assign ev = elem_done & ~elem_done_q;
  assign start = ev & ~element_type;
  assign stop = ev & element_type;
  assign trailing = start & (state == S_DONE);
  assign ovf = start & (state != S_DONE) & ((sp == FULL) | (next_id == SAT));
  assign emit = start & (state != S_DONE) & ~((sp == FULL) | (next_id == SAT));
  assign push = emit & (element_tag != `ELE_TAG_BITES'(4));
  assign pop = stop & (sp != '0);
  assign underflow = stop & (sp == '0);
  assign top_i = IW'(sp - 1'b1);
  assign mismatch = pop & (stk_tag[top_i] != element_tag);
  always_comb begin
    state_n = (pop && sp == SP_BITS'(1)) ? S_DONE : (emit && state == S_EMPTY) ? S_OPEN : state;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= S_EMPTY;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (push) begin
      stk_tag[IW'(sp)] <= element_tag;
      stk_id[IW'(sp)] <= next_id;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      elem_done_q <= 1'b0;
      sp <= '0;
      next_id <= '0;
      node_valid <= 1'b0;
      node_id <= '0;
      node_tag <= '0;
      node_parent <= '0;
      node_depth <= '0;
      close_valid <= 1'b0;
      close_id <= '0;
      doc_done <= 1'b0;
      err_flags <= '0;
    end else begin
      elem_done_q <= elem_done;
      node_valid <= emit;
      close_valid <= pop;
      err_flags <= err_flags | {trailing, ovf, underflow, mismatch};
      if (emit) begin
        node_id <= next_id;
        node_tag <= element_tag;
        node_parent <= (sp == '0) ? ROOT : stk_id[top_i];
        node_depth <= sp;
        next_id <= next_id + 1'b1;
      end
      if (push) sp <= sp + 1'b1;
      if (pop) begin
        sp <= sp - 1'b1;
        close_id <= stk_id[top_i];
      end
      if (pop && sp == SP_BITS'(1)) doc_done <= 1'b1;
    end
  end
`ifdef ELEMENT_STACK_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      max_depth <= '0;
      node_count <= '0;
    end else begin
      if (push && (sp + 1'b1) > max_depth) max_depth <= sp + 1'b1;
      if (emit) node_count <= node_count + 1'b1;
    end
  end
`else
  assign max_depth = '0;
  assign node_count = '0;
`endif
endmodule

// File: tb/tb_element_stack.sv
// tb_element_stack: directed table and sequence checks for element_stack
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 3
`endif
module tb_element_stack;
  localparam logic [2:0] DIV = 3'd0, P = 3'd1, BODY = 3'd2, A = 3'd3, IMG = 3'd4;
  logic clock = 1'b0, reset = 1'b1, elem_done = 1'b0, element_type = 1'b0;
  logic [`ELE_TAG_BITES-1:0] element_tag = '0;
  logic node_valid, close_valid, doc_done;
  logic [7:0] node_id, node_parent, close_id, node_count;
  logic [`ELE_TAG_BITES-1:0] node_tag;
  logic [4:0] node_depth, max_depth;
  logic [3:0] err_flags;
  int total = 0, passed = 0, cnt;
  logic s_nv, s_cv, s_done;
  logic [7:0] s_id, s_par, s_cid;
  logic [2:0] s_tag;
  logic [4:0] s_dep;
  logic [3:0] s_err;
  typedef struct {
    logic et; logic [2:0] tag;
    logic nv; logic [7:0] id; logic [2:0] ntag; logic [7:0] par; logic [4:0] dep;
    logic cv; logic [7:0] cid; logic done; logic [3:0] err;
  } vec_t;
  vec_t tbl [7];
  element_stack dut (
    .clock(clock), .reset(reset), .elem_done(elem_done), .element_tag(element_tag),
    .element_type(element_type), .node_valid(node_valid), .node_id(node_id),
    .node_tag(node_tag), .node_parent(node_parent), .node_depth(node_depth),
    .close_valid(close_valid), .close_id(close_id), .doc_done(doc_done),
    .err_flags(err_flags), .max_depth(max_depth), .node_count(node_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    elem_done = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask
  task automatic ev(input logic et, input logic [2:0] tg);
    element_type = et;
    element_tag = tg;
    elem_done = 1'b1;
    @(posedge clock);
    #1;
    s_nv = node_valid; s_id = node_id; s_tag = node_tag; s_par = node_parent; s_dep = node_depth;
    s_cv = close_valid; s_cid = close_id; s_done = doc_done; s_err = err_flags;
    elem_done = 1'b0;
    @(posedge clock);
    #1;
    chk("pulse_one_cycle", {30'd0, node_valid, close_valid}, 0);
  endtask
  initial begin
    tbl[0] = '{0, BODY, 1, 8'd0, BODY, 8'hFF, 5'd0, 0, 8'd0, 0, 4'h0};
    tbl[1] = '{0, DIV,  1, 8'd1, DIV,  8'd0,  5'd1, 0, 8'd0, 0, 4'h0};
    tbl[2] = '{0, P,    1, 8'd2, P,    8'd1,  5'd2, 0, 8'd0, 0, 4'h0};
    tbl[3] = '{1, P,    0, 8'd0, 3'd0, 8'd0,  5'd0, 1, 8'd2, 0, 4'h0};
    tbl[4] = '{1, DIV,  0, 8'd0, 3'd0, 8'd0,  5'd0, 1, 8'd1, 0, 4'h0};
    tbl[5] = '{1, BODY, 0, 8'd0, 3'd0, 8'd0,  5'd0, 1, 8'd0, 1, 4'h0};
    tbl[6] = '{0, DIV,  0, 8'd0, 3'd0, 8'd0,  5'd0, 0, 8'd0, 1, 4'h8};
    do_reset();
    chk("reset_outputs", {node_valid, node_id, node_tag, node_parent, node_depth, close_valid,
                          close_id, doc_done, err_flags, max_depth, node_count}, 0);
    for (int k = 0; k < 7; k++) begin
      ev(tbl[k].et, tbl[k].tag);
      chk($sformatf("v%0d_node_valid", k), 32'(s_nv), 32'(tbl[k].nv));
      if (tbl[k].nv) begin
        chk($sformatf("v%0d_node_id", k), 32'(s_id), 32'(tbl[k].id));
        chk($sformatf("v%0d_node_tag", k), 32'(s_tag), 32'(tbl[k].ntag));
        chk($sformatf("v%0d_node_parent", k), 32'(s_par), 32'(tbl[k].par));
        chk($sformatf("v%0d_node_depth", k), 32'(s_dep), 32'(tbl[k].dep));
      end
      chk($sformatf("v%0d_close_valid", k), 32'(s_cv), 32'(tbl[k].cv));
      if (tbl[k].cv) chk($sformatf("v%0d_close_id", k), 32'(s_cid), 32'(tbl[k].cid));
      chk($sformatf("v%0d_doc_done", k), 32'(s_done), 32'(tbl[k].done));
      chk($sformatf("v%0d_err", k), 32'(s_err), 32'(tbl[k].err));
    end
    chk("record_hold_id", 32'(node_id), 2);
    do_reset();
    ev(0, BODY);
    ev(0, IMG);
    chk("img_node", {s_nv, s_id, s_par, s_dep, s_cv}, {1'b1, 8'd1, 8'd0, 5'd1, 1'b0});
    ev(1, BODY);
    chk("img_close", {s_cv, s_cid, s_done, s_err}, {1'b1, 8'd0, 1'b1, 4'h0});
    do_reset();
    ev(0, BODY);
    ev(0, DIV);
    ev(1, P);
    chk("mismatch", {s_cv, s_cid, s_done, s_err}, {1'b1, 8'd1, 1'b0, 4'h1});
    ev(1, BODY);
    chk("mismatch_recover", {s_cv, s_cid, s_done, s_err}, {1'b1, 8'd0, 1'b1, 4'h1});
    do_reset();
    ev(1, DIV);
    chk("underflow", {s_nv, s_cv, s_err}, {1'b0, 1'b0, 4'h2});
    ev(0, BODY);
    chk("after_underflow", {s_nv, s_id, s_par}, {1'b1, 8'd0, 8'hFF});
    do_reset();
    cnt = 0;
    for (int k = 0; k < 17; k++) begin
      ev(0, DIV);
      cnt += int'(s_nv);
      if (k == 15) chk("deepest_node", {s_id, s_par, s_dep, s_err}, {8'd15, 8'd14, 5'd15, 4'h0});
    end
    chk("overflow_nodes", cnt, 16);
    chk("overflow_flag", {s_nv, s_err}, {1'b0, 4'h4});
`ifdef ELEMENT_STACK_STATS_EN
    chk("max_depth", 32'(max_depth), 16);
    chk("node_count", 32'(node_count), 16);
`else
    chk("stats_off", {max_depth, node_count}, 0);
`endif
    do_reset();
    for (int k = 0; k < 254; k++) ev(0, IMG);
    chk("sat_last_node", {s_nv, s_id, s_par, s_dep, s_err}, {1'b1, 8'd253, 8'hFF, 5'd0, 4'h0});
    ev(0, IMG);
    chk("sat_overflow", {s_nv, s_err}, {1'b0, 4'h4});
`ifdef ELEMENT_STACK_STATS_EN
    chk("sat_node_count", 32'(node_count), 254);
`endif
    do_reset();
    element_type = 1'b0;
    element_tag = BODY;
    elem_done = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(posedge clock);
      #1 cnt += int'(node_valid);
    end
    elem_done = 1'b0;
    @(posedge clock);
    #1 chk("held_single_node", cnt, 1);
    ev(0, DIV);
    chk("held_then_div", {s_nv, s_id, s_par}, {1'b1, 8'd1, 8'd0});
    reset = 1'b1;
    @(posedge clock);
    #1 chk("midreset_outputs", {node_valid, node_id, node_tag, node_parent, node_depth, close_valid,
                                close_id, doc_done, err_flags, max_depth, node_count}, 0);
    reset = 1'b0;
    ev(0, A);
    chk("midreset_next", {s_nv, s_id, s_tag, s_par, s_dep}, {1'b1, 8'd0, A, 8'hFF, 5'd0});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
